// File: rtl/r5p_pkg.sv
// Shared R5P types: the per-cycle HPM event vector, the mhpmevent layout and HPM CSR addresses.
package r5p_pkg;

    // one bit per countable core event, bit 0 first from the bottom
    typedef struct packed {
        logic br_taken;    // 12
        logic branch;      // 11
        logic jump;        // 10
        logic st_wait;     // 9
        logic ld_wait;     // 8
        logic store;       // 7
        logic load;        // 6
        logic if_wait;     // 5
        logic fence;       // 4
        logic compressed;  // 3
        logic instret;     // 2
        logic tick;        // 1
        logic cycle;       // 0
    } r5p_hpmevent_t;

    localparam int unsigned HPM_EW = $bits(r5p_hpmevent_t);

    typedef struct packed {
        logic              of;
        logic [30:HPM_EW]  rsv;
        r5p_hpmevent_t     mask;
    } r5p_hpmctl_t;

    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_MHPMEVENT3    = 12'h323;
    localparam logic [11:0] CSR_MHPMCOUNTER3  = 12'hB03;
    localparam logic [11:0] CSR_MHPMCOUNTERH3 = 12'hB83;

    localparam logic [11:0] HPM_SLOTS = 12'd29;

endpackage

// File: rtl/r5p_hpm_counter.sv
// One 64-bit HPM counter; a software write to either half drops that cycle's increment.
module r5p_hpm_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdt,
    output logic [63:0] cnt,
    output logic        wrap
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (wr_lo) begin
            cnt[31:0] <= wdt;
        end else if (wr_hi) begin
            cnt[63:32] <= wdt;
        end else if (inc) begin
            cnt <= cnt + 64'd1;
        end
    end

    assign wrap = inc && !wr_lo && !wr_hi && (&cnt);

endmodule

// File: rtl/r5p_hpm_ctl.sv
// Machine-mode HPM controller: CNT counters, event selectors and mcountinhibit behind a CSR port.
// Overflow flags and irq_ovf exist only when R5P_HPM_OVF_EN is defined.
module r5p_hpm_ctl
    import r5p_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned CNT  = 4,
    parameter int unsigned EW   = $bits(r5p_hpmevent_t)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [EW-1:0]   evt,
    input  logic            csr_vld,
    input  logic            csr_wen,
    input  logic [11:0]     csr_adr,
    input  logic [XLEN-1:0] csr_wdt,
    output logic            csr_rsp,
    output logic [XLEN-1:0] csr_rdt,
    output logic            csr_err,
    output logic            irq_ovf
);

`ifdef R5P_HPM_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic [11:0]     off_evt, off_lo, off_hi;
    logic            sel_inh, sel_evt, sel_lo, sel_hi, sel_any;
    logic [4:0]      idx;
    logic            wr;
    logic [CNT-1:0]  inh_reg;
    logic [EW-1:0]   mask_reg [CNT];
    logic [CNT-1:0]  of_reg;
    logic [63:0]     cnt [CNT];
    logic [CNT-1:0]  wrap;
    logic [XLEN-1:0] rd;
    logic            irq_reg;

    // below-base addresses wrap to large offsets and fall out of range
    assign off_evt = csr_adr - CSR_MHPMEVENT3;
    assign off_lo  = csr_adr - CSR_MHPMCOUNTER3;
    assign off_hi  = csr_adr - CSR_MHPMCOUNTERH3;
    assign sel_inh = (csr_adr == CSR_MCOUNTINHIBIT);
    assign sel_evt = (off_evt < HPM_SLOTS);
    assign sel_lo  = (off_lo  < HPM_SLOTS);
    assign sel_hi  = (off_hi  < HPM_SLOTS);
    assign sel_any = sel_inh | sel_evt | sel_lo | sel_hi;
    assign idx     = sel_evt ? off_evt[4:0] : (sel_lo ? off_lo[4:0] : off_hi[4:0]);
    assign wr      = csr_vld && csr_wen;

    always_comb begin
        r5p_hpmctl_t ctl;
        rd  = '0;
        ctl = '0;
        if (sel_inh) begin
            rd[3 +: CNT] = inh_reg;
        end
        for (int i = 0; i < CNT; i++) begin
            if (idx == 5'(i)) begin
                if (sel_evt) begin
                    ctl      = '0;
                    ctl.mask = r5p_hpmevent_t'(mask_reg[i]);
                    ctl.of   = of_reg[i];
                    rd       = ctl;
                end
                if (sel_lo) rd = cnt[i][31:0];
                if (sel_hi) rd = cnt[i][63:32];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inh_reg <= '0;
            csr_rsp <= 1'b0;
            csr_rdt <= '0;
            csr_err <= 1'b0;
            irq_reg <= 1'b0;
        end else begin
            if (wr && sel_inh) inh_reg <= csr_wdt[3 +: CNT];
            csr_rsp <= csr_vld;
            csr_rdt <= csr_vld ? rd : '0;
            csr_err <= csr_vld && !sel_any;
            irq_reg <= OVF_EN && (|of_reg);
        end
    end

    assign irq_ovf = irq_reg;

    generate
        for (genvar gi = 0; gi < CNT; gi++) begin : g_cnt
            logic hit;
            logic wr_evt;

            assign hit    = idx == 5'(gi);
            assign wr_evt = wr && sel_evt && hit;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    mask_reg[gi] <= '0;
                    of_reg[gi]   <= 1'b0;
                end else begin
                    if (wr_evt) mask_reg[gi] <= csr_wdt[EW-1:0];
                    // a wrap in the same cycle overrides a software clear
                    if (OVF_EN && wrap[gi])   of_reg[gi] <= 1'b1;
                    else if (OVF_EN && wr_evt) of_reg[gi] <= csr_wdt[XLEN-1];
                end
            end

            r5p_hpm_counter u_cnt (
                .clk   (clk),
                .rst   (rst),
                .inc   ((|(evt & mask_reg[gi])) && !inh_reg[gi]),
                .wr_lo (wr && sel_lo && hit),
                .wr_hi (wr && sel_hi && hit),
                .wdt   (csr_wdt),
                .cnt   (cnt[gi]),
                .wrap  (wrap[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_r5p_hpm_ctl.sv
// Directed self-checking bench for r5p_hpm_ctl (CNT=4); OF checks follow R5P_HPM_OVF_EN.
module tb_r5p_hpm_ctl;

    logic        clk = 1'b0;
    logic        rst;
    logic [12:0] evt;
    logic        csr_vld, csr_wen;
    logic [11:0] csr_adr;
    logic [31:0] csr_wdt;
    logic        csr_rsp;
    logic [31:0] csr_rdt;
    logic        csr_err;
    logic        irq_ovf;

    int total = 0;
    int bad   = 0;

    logic [31:0] rv;
    logic        re;

`ifdef R5P_HPM_OVF_EN
    localparam logic [31:0] EV_ALL = 32'h8000_1FFF;
    localparam logic [31:0] EV_WRAP = 32'h8000_0060;
    localparam logic        IRQ_WRAP = 1'b1;
`else
    localparam logic [31:0] EV_ALL = 32'h0000_1FFF;
    localparam logic [31:0] EV_WRAP = 32'h0000_0060;
    localparam logic        IRQ_WRAP = 1'b0;
`endif

    r5p_hpm_ctl #(.XLEN(32), .CNT(4), .EW(13)) dut (
        .clk     (clk),
        .rst     (rst),
        .evt     (evt),
        .csr_vld (csr_vld),
        .csr_wen (csr_wen),
        .csr_adr (csr_adr),
        .csr_wdt (csr_wdt),
        .csr_rsp (csr_rsp),
        .csr_rdt (csr_rdt),
        .csr_err (csr_err),
        .irq_ovf (irq_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // one CSR access; returns the response sampled 1ns after the response edge
    task automatic csr(input logic wen, input logic [11:0] adr, input logic [31:0] wdt,
                       output logic [31:0] rdt, output logic err);
        @(negedge clk);
        csr_vld = 1'b1;
        csr_wen = wen;
        csr_adr = adr;
        csr_wdt = wdt;
        @(posedge clk);
        #1;
        csr_vld = 1'b0;
        csr_wen = 1'b0;
        rdt = csr_rdt;
        err = csr_err;
        $display("csr wen=%0d adr=%03h wdt=%08h -> rsp=%0d rdt=%08h err=%0d",
                 wen, adr, wdt, csr_rsp, rdt, err);
        if (!csr_rsp) chk("rsp_strobe", {63'd0, csr_rsp}, 64'd1);
    endtask

    task automatic run_evt(input logic [12:0] v, input int n);
        @(negedge clk);
        evt = v;
        repeat (n) @(posedge clk);
        #1;
        evt = '0;
        $display("evt %04h for %0d cycles", v, n);
    endtask

    initial begin
        rst = 1'b0; evt = '0;
        csr_vld = 1'b0; csr_wen = 1'b0; csr_adr = '0; csr_wdt = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rsp", {63'd0, csr_rsp}, 64'd0);
        chk("reset_rdt", {32'd0, csr_rdt}, 64'd0);
        chk("reset_irq", {63'd0, irq_ovf}, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // map
        csr(1'b0, 12'hB03, 32'h0, rv, re);
        chk("rd_b03", rv, 0); chk("rd_b03_err", re, 0);
        csr(1'b0, 12'h7C0, 32'h0, rv, re);
        chk("rd_7c0_err", re, 1); chk("rd_7c0_rdt", rv, 0);

        // mhpmevent read-back masking
        csr(1'b1, 12'h323, 32'hFFFF_FFFF, rv, re);
        csr(1'b0, 12'h323, 32'h0, rv, re);
        chk("ev_all", rv, EV_ALL);

        // instret counting
        csr(1'b1, 12'h323, 32'h0000_0004, rv, re);
        run_evt(13'h0004, 10);
        csr(1'b0, 12'hB03, 32'h0, rv, re);
        chk("cnt_10", rv, 10);
        csr(1'b0, 12'hB83, 32'h0, rv, re);
        chk("cnth_0", rv, 0);

        // two matching events in a cycle count once
        csr(1'b1, 12'h323, 32'h0000_0060, rv, re);
        run_evt(13'h0060, 5);
        csr(1'b0, 12'hB03, 32'h0, rv, re);
        chk("cnt_15", rv, 15);

        // inhibit
        csr(1'b1, 12'h320, 32'h0000_0008, rv, re);
        run_evt(13'h0060, 5);
        csr(1'b0, 12'hB03, 32'h0, rv, re);
        chk("cnt_inh", rv, 15);
        csr(1'b0, 12'h320, 32'h0, rv, re);
        chk("inh_rd", rv, 32'h8);
        csr(1'b1, 12'h320, 32'hFFFF_FFFF, rv, re);
        csr(1'b0, 12'h320, 32'h0, rv, re);
        chk("inh_mask", rv, 32'h78);
        csr(1'b1, 12'h320, 32'h0, rv, re);

        // carry lo -> hi
        csr(1'b1, 12'hB03, 32'hFFFF_FFFE, rv, re);
        csr(1'b1, 12'hB83, 32'h0, rv, re);
        run_evt(13'h0020, 3);
        csr(1'b0, 12'hB03, 32'h0, rv, re);
        chk("carry_lo", rv, 1);
        csr(1'b0, 12'hB83, 32'h0, rv, re);
        chk("carry_hi", rv, 1);

        // full wrap
        csr(1'b1, 12'hB03, 32'hFFFF_FFFF, rv, re);
        csr(1'b1, 12'hB83, 32'hFFFF_FFFF, rv, re);
        run_evt(13'h0040, 1);
        csr(1'b0, 12'hB03, 32'h0, rv, re);
        chk("wrap_lo", rv, 0);
        csr(1'b0, 12'hB83, 32'h0, rv, re);
        chk("wrap_hi", rv, 0);
        csr(1'b0, 12'h323, 32'h0, rv, re);
        chk("wrap_of", rv, EV_WRAP);
        chk("wrap_irq", irq_ovf, IRQ_WRAP);
        csr(1'b1, 12'h323, 32'h0000_0060, rv, re);

        // write beats same-cycle increment
        @(negedge clk);
        evt = 13'h0060;
        csr_vld = 1'b1; csr_wen = 1'b1; csr_adr = 12'hB03; csr_wdt = 32'h100;
        @(posedge clk);
        #1;
        evt = '0; csr_vld = 1'b0; csr_wen = 1'b0;
        $display("collision write b03=100 with event");
        csr(1'b0, 12'hB03, 32'h0, rv, re);
        chk("collide", rv, 32'h100);

        // unimplemented index
        csr(1'b1, 12'hB07, 32'h55, rv, re);
        chk("b07_wr_err", re, 0);
        csr(1'b0, 12'hB07, 32'h0, rv, re);
        chk("b07_rd", rv, 0); chk("b07_rd_err", re, 0);
        csr(1'b0, 12'h327, 32'h0, rv, re);
        chk("ev7_rd", rv, 0);
        csr(1'b0, 12'hB03, 32'h0, rv, re);
        chk("c3_kept", rv, 32'h100);
        for (int i = 1; i < 4; i++) begin
            csr(1'b0, 12'hB03 + 12'(i), 32'h0, rv, re);
            chk("cx_zero", rv, 0);
        end
        csr(1'b0, 12'h33F, 32'h0, rv, re);
        chk("ev28_err", re, 0);
        csr(1'b0, 12'h340, 32'h0, rv, re);
        chk("ev_past_err", re, 1);

        // asynchronous reset while counting with a response in flight
        @(negedge clk);
        evt = 13'h0060;
        csr_vld = 1'b1; csr_wen = 1'b0; csr_adr = 12'hB03;
        @(posedge clk);
        #2;
        chk("pre_rst_rsp", csr_rsp, 1);
        rst = 1'b0;
        #1;
        chk("async_rsp", csr_rsp, 0);
        chk("async_rdt", csr_rdt, 0);
        chk("async_irq", irq_ovf, 0);
        csr_vld = 1'b0; evt = '0;
        @(negedge clk);
        rst = 1'b1;
        csr(1'b0, 12'hB03, 32'h0, rv, re);
        chk("post_rst_cnt", rv, 0);
        csr(1'b0, 12'h323, 32'h0, rv, re);
        chk("post_rst_ev", rv, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
